uart_tx_fifo: RTL and testbench

- UART transmitter with a small transmit FIFO. Frame format is 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- It is the companion of the board's 8N1 receiver and uses the same bit timing, so the motor board can stream reply bytes back to the host at 250000 baud from a 16 MHz clock.
- Upstream logic pushes bytes through a valid/ready handshake. The block drains the FIFO back-to-back onto the serial line.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo.sv | 136 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions: frame constants, default bit timing and the
// transmitter state encoding. The receiver uses the same frame constants.
package uart_pkg;

    // 16 MHz / 64 = 250000 baud
    localparam int DEFAULT_CLKS_PER_BIT = 64;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with wrapping pointers and an explicit count.
// Read data falls through from the head entry, so a pop consumes rd_data.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   count_t;

    localparam ptr_t   PTR_ONE    = ptr_t'(1);
    localparam count_t COUNT_ONE  = count_t'(1);
    localparam count_t COUNT_FULL = count_t'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Full/empty come from the registered count, so a push while full is
    // dropped even when a pop frees a slot in the same cycle.
    assign full    = (count == COUNT_FULL);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                // NOTE: the default arm keeps the case complete; in combinational
                // code a missing arm would infer a latch.
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the count and pointers alone define which
    // entries are valid, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge i_Clock) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small FIFO; queued bytes are sent
// back-to-back with no idle gap while the FIFO stays non-empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Tx_DV,
    input  logic [7:0]                 i_Tx_Byte,
    output logic                       o_Tx_Ready,
    output logic                       o_Tx_Serial,
    output logic                       o_Tx_Active,
    output logic                       o_Tx_Done,
    output logic [FIFO_DEPTH_LOG2:0]   o_Fifo_Count
);

    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [7:0]       LAST_CLK = 8'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    tx_state_t              state;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [7:0]             clk_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [IDX_W-1:0]       next_idx;
    logic                   bit_done;
    logic                   fifo_pop;
    logic [7:0]             fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .push    (i_Tx_DV),
        .wr_data (i_Tx_Byte),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .count   (o_Fifo_Count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign o_Tx_Ready = !fifo_full;
    assign bit_done   = (clk_cnt == LAST_CLK);
    assign next_idx   = bit_idx + IDX_ONE;

    // Pop from IDLE, or in the final STOP cycle so the next start bit follows
    // the stop bit with no gap.
    assign fifo_pop = !fifo_empty && ((state == IDLE) || (state == STOP && bit_done));

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            o_Tx_Serial <= STOP_BIT;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;
            case (state)
                IDLE: begin
                    o_Tx_Serial <= STOP_BIT;
                    o_Tx_Active <= 1'b0;
                    if (fifo_pop) begin
                        shift_reg   <= fifo_rd_data;
                        clk_cnt     <= '0;
                        bit_idx     <= '0;
                        o_Tx_Serial <= START_BIT;
                        o_Tx_Active <= 1'b1;
                        state       <= START;
                    end
                end

                START: begin
                    if (bit_done) begin
                        clk_cnt     <= '0;
                        bit_idx     <= '0;
                        o_Tx_Serial <= shift_reg[0];
                        state       <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 8'd1;
                    end
                end

                // The line register is loaded one bit ahead, so it always
                // shows shift_reg[bit_idx] while in DATA.
                DATA: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            o_Tx_Serial <= STOP_BIT;
                            state       <= STOP;
                        end else begin
                            bit_idx     <= next_idx;
                            o_Tx_Serial <= shift_reg[next_idx];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 8'd1;
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        clk_cnt   <= '0;
                        o_Tx_Done <= 1'b1;
                        if (fifo_pop) begin
                            shift_reg   <= fifo_rd_data;
                            bit_idx     <= '0;
                            o_Tx_Serial <= START_BIT;
                            state       <= START;
                        end else begin
                            o_Tx_Active <= 1'b0;
                            state       <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a frame-position model compared every
// cycle, a loopback 8N1 receiver, and hand-computed literal checkpoints.
module tb_uart_tx_fifo;

    localparam int C     = 64;
    localparam int DLOG2 = 2;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * C;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           dv  = 1'b0;
    logic [7:0]     tx_byte = 8'h00;
    logic           ready;
    logic           serial;
    logic           active;
    logic           done;
    logic [DLOG2:0] fcount;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT    (C),
        .FIFO_DEPTH_LOG2 (DLOG2)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Tx_DV      (dv),
        .i_Tx_Byte    (tx_byte),
        .o_Tx_Ready   (ready),
        .o_Tx_Serial  (serial),
        .o_Tx_Active  (active),
        .o_Tx_Done    (done),
        .o_Fifo_Count (fcount)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];
    logic [7:0] m_byte;
    bit         m_busy = 0;
    bit         m_done = 0;
    bit         m_live = 0;
    bit         m_ready;
    int         m_t = 0;

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_busy = 0;
            m_done = 0;
            m_t    = 0;
            m_live = 1;
        end else if (m_live) begin
            m_ready = (m_q.size() < DEPTH);
            m_done  = 0;
            if (m_busy && m_t == FRAME - 1) begin
                m_done = 1;
                m_busy = 0;
            end else if (m_busy) begin
                m_t++;
            end
            if (!m_busy && m_q.size() > 0) begin
                m_byte = m_q.pop_front();
                m_busy = 1;
                m_t    = 0;
            end
            if (dv && m_ready) m_q.push_back(tx_byte);
        end
    end

    // Per-cycle compare plus window statistics used by the directed tests.
    int low_cnt = 0, act_low_cnt = 0, done_cnt = 0, max_count = 0;
    logic [6:0] exp_vec, act_vec;

    always @(negedge clk) begin
        if (m_live) begin
            exp_vec = {(m_busy ? frame_bit(m_byte, m_t / C) : 1'b1), m_busy, m_done,
                       (m_q.size() < DEPTH), 3'(m_q.size())};
            act_vec = {serial, active, done, ready, fcount};
            check("model serial/active/done/ready/count", {25'd0, act_vec}, {25'd0, exp_vec});
            if (serial == 1'b0) low_cnt++;
            if (active == 1'b0) act_low_cnt++;
            if (done) done_cnt++;
            if (int'(fcount) > max_count) max_count = int'(fcount);
        end
    end

    // ---------------- loopback receiver ----------------
    int         rx_st = 0, rx_cnt = 0, rx_bit = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_q[$];

    always @(posedge clk) begin
        if (rst) begin
            rx_st = 0;
        end else begin
            case (rx_st)
                0: if (serial === 1'b0) begin rx_st = 1; rx_cnt = 0; end
                1: begin
                    rx_cnt++;
                    if (rx_cnt == C / 2) begin
                        if (serial === 1'b0) begin rx_st = 2; rx_cnt = 0; rx_bit = 0; end
                        else rx_st = 0;
                    end
                end
                2: begin
                    rx_cnt++;
                    if (rx_cnt == C) begin
                        rx_cnt = 0;
                        rx_sh[rx_bit] = serial;
                        rx_bit++;
                        if (rx_bit == 8) rx_st = 3;
                    end
                end
                default: begin
                    rx_cnt++;
                    if (rx_cnt == C) begin
                        if (serial === 1'b1) rx_q.push_back(rx_sh);
                        rx_st = 0;
                    end
                end
            endcase
        end
    end

    task automatic check_rx(input string name, input int idx, input logic [7:0] exp);
        check(name, (idx < rx_q.size()) ? {24'd0, rx_q[idx]} : 32'hDEAD_BEEF, {24'd0, exp});
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        dv      = 1'b1;
        tx_byte = b;
        @(posedge clk);
        #1;
        dv = 1'b0;
    endtask

    logic [7:0] bits_55   [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    logic [7:0] burst_a   [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    int         cnt_a     [5] = '{1, 1, 2, 3, 4};
    logic [7:0] burst_b   [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int         cnt_b     [6] = '{1, 1, 2, 3, 4, 4};
    int         rdy_b     [6] = '{1, 1, 1, 1, 0, 0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset: line high, nothing queued.
        n = cyc;
        at_cycle(n);
        low_cnt = 0; act_low_cnt = 0; done_cnt = 0;
        at_cycle(n + 1000);
        check("idle line low cycles", low_cnt, 0);
        check("idle active low cycles", act_low_cnt, 1000);
        check("idle done pulses", done_cnt, 0);
        check("idle serial", serial, 1);
        check("idle ready", ready, 1);
        check("idle count", fcount, 0);

        // Single byte 0x55: latency, bit order, done pulse timing.
        rx_q.delete();
        n = cyc;
        push(8'h55);
        check("55 count at N+1", fcount, 1);
        check("55 serial at N+1", serial, 1);
        at_cycle(n + 2);
        check("55 start bit at N+2", serial, 0);
        check("55 active at N+2", active, 1);
        check("55 count at N+2", fcount, 0);
        at_cycle(n + 65);
        check("55 start bit at N+65", serial, 0);
        for (int k = 0; k < 8; k++) begin
            at_cycle(n + 98 + 64 * k);
            check("55 data bit", serial, bits_55[k]);
        end
        at_cycle(n + 610);
        check("55 stop bit", serial, 1);
        at_cycle(n + 641);
        check("55 done at N+641", done, 0);
        check("55 active at N+641", active, 1);
        at_cycle(n + 642);
        check("55 done at N+642", done, 1);
        check("55 active at N+642", active, 0);
        at_cycle(n + 643);
        check("55 done at N+643", done, 0);
        at_cycle(n + 660);
        check("55 rx count", rx_q.size(), 1);
        check_rx("55 rx byte", 0, 8'h55);

        // Five consecutive pushes: all accepted, sent back-to-back.
        at_cycle(n + 700);
        rx_q.delete();
        n = cyc;
        for (int i = 0; i < 5; i++) begin
            push(burst_a[i]);
            check("burst5 count", fcount, cnt_a[i]);
        end
        act_low_cnt = 0; done_cnt = 0;
        at_cycle(n + 3201);
        check("burst5 active gaps", act_low_cnt, 0);
        check("burst5 done pulses before last", done_cnt, 4);
        at_cycle(n + 3202);
        check("burst5 last done", done, 1);
        check("burst5 active after last", active, 0);
        at_cycle(n + 3220);
        check("burst5 rx count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) check_rx("burst5 rx byte", i, burst_a[i]);

        // Six pushes: the sixth meets a full FIFO and is dropped.
        rx_q.delete();
        max_count = 0;
        n = cyc;
        for (int i = 0; i < 6; i++) begin
            push(burst_b[i]);
            check("full count", fcount, cnt_b[i]);
            check("full ready", ready, rdy_b[i]);
        end
        at_cycle(n + 3220);
        check("full max count", max_count, 4);
        check("full rx count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) check_rx("full rx byte", i, burst_b[i]);

        // Reset in the middle of data bit 3 of 0xC3 with two bytes queued.
        rx_q.delete();
        done_cnt = 0;
        n = cyc;
        push(8'hC3);
        push(8'h12);
        push(8'h34);
        check("abort queued count", fcount, 2);
        at_cycle(n + 290);
        check("abort bit3 of C3", serial, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort serial after reset", serial, 1);
        check("abort count after reset", fcount, 0);
        check("abort active after reset", active, 0);
        check("abort done after reset", done, 0);
        at_cycle(n + 291);
        low_cnt = 0;
        at_cycle(n + 1500);
        check("abort line low after reset", low_cnt, 0);
        check("abort done pulses", done_cnt, 0);
        check("abort rx count", rx_q.size(), 0);

        // Byte arriving so it is queued during the last stop cycle.
        rx_q.delete();
        n = cyc;
        push(8'h5A);
        at_cycle(n + 640);
        check("b2b count before", fcount, 0);
        push(8'h96);
        check("b2b count in last stop", fcount, 1);
        check("b2b serial in last stop", serial, 1);
        at_cycle(n + 642);
        check("b2b count after pop", fcount, 0);
        check("b2b next start bit", serial, 0);
        check("b2b active held", active, 1);
        check("b2b first done", done, 1);
        at_cycle(n + 1282);
        check("b2b second done", done, 1);
        check("b2b active dropped", active, 0);
        at_cycle(n + 1300);
        check("b2b rx count", rx_q.size(), 2);
        check_rx("b2b rx byte 0", 0, 8'h5A);
        check_rx("b2b rx byte 1", 1, 8'h96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
